// File: rtl/dac_pkg.sv
// Shared types and helpers for the multi-channel DAC controller.
// The real-valued conversion helper is only called when DAC_REAL_OUT_EN is defined.
package dac_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } dac_state_e;

   // Channel index width; a single-channel build still gets a 1-bit index.
   function automatic int ch_idx_w(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   // Channel index width for the default 4-channel build.
   localparam int CHW_DEFAULT = ch_idx_w(4);

   // Weighted sum of bit_i * 2^i, scaled by vref / 2^w.
   function automatic real code_to_volts(input logic [15:0] code, input int w, input real vref);
      real acc;
      real lsb;
      acc = 0.0;
      lsb = vref / (2.0 ** w);
      for (int i = 0; i < w; i++) begin
         if (code[i]) acc = acc + lsb * (2.0 ** i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/dac_chan_reg.sv
// One DAC channel: staging register, conversion snapshot and held output code.
// A write on the snapshot edge is captured directly (write-through).
module dac_chan_reg #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr,
   input  logic [W-1:0] wr_data,
   input  logic         snap,
   input  logic         commit,
   output logic [W-1:0] code
);

   logic [W-1:0] staging;
   logic [W-1:0] snapshot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         staging  <= '0;
         snapshot <= '0;
         code     <= '0;
      end else begin
         if (wr) staging <= wr_data;
         if (snap) snapshot <= wr ? wr_data : staging;
         if (commit) code <= snapshot;
      end
   end

endmodule

// File: rtl/dac_multich.sv
// N-channel DAC controller: soc snapshots staging codes, commits them after SETTLE_CYC.
// Define DAC_REAL_OUT_EN to add the simulation-only real a_out model.
//
// state  | meaning
// IDLE   | waiting for soc; staging writes accepted
// SETTLE | counting down the settling time; commit and eoc when count hits 0
module dac_multich
   import dac_pkg::*;
#(
   parameter int  NCH        = 4,
   parameter int  W          = 12,
   parameter int  SETTLE_CYC = 4,
   parameter real VREF       = 3.3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [ch_idx_w(NCH)-1:0]      wr_ch,
   input  logic [W-1:0]                  wr_data,
   input  logic                          soc,
   input  logic                          all_ch,
   input  logic [ch_idx_w(NCH)-1:0]      soc_ch,
   output logic                          busy,
   output logic                          eoc,
   output logic                          ovr,
   output logic [NCH*W-1:0]              code_out
`ifdef DAC_REAL_OUT_EN
   ,
   output real                           a_out [NCH]
`endif
);

   localparam int CHW = ch_idx_w(NCH);
   localparam int CW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC - 1);

   dac_state_e      state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            all_l;
   logic [CHW-1:0]  ch_l;
   logic            accept;
   logic            done;

   assign accept = (state == IDLE) && soc;
   assign done   = (state == SETTLE) && (cnt == '0);
   assign busy   = (state == SETTLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (soc) begin
               state_nxt = SETTLE;
               cnt_nxt   = CNT_LOAD;
            end
         end
         SETTLE: begin
            if (cnt == '0) state_nxt = IDLE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         all_l <= 1'b0;
         ch_l  <= '0;
         eoc   <= 1'b0;
         ovr   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         eoc   <= done;
         if (accept) begin
            all_l <= all_ch;
            ch_l  <= soc_ch;
         end
         // The eoc edge is still SETTLE, so a soc there is dropped too.
         if (soc && (state == SETTLE)) ovr <= 1'b1;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      dac_chan_reg #(.W(W)) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr      (wr_en && (wr_ch == CHW'(c))),
         .wr_data (wr_data),
         .snap    (accept),
         .commit  (done && (all_l || (ch_l == CHW'(c)))),
         .code    (code_out[c*W +: W])
      );
   end

`ifdef DAC_REAL_OUT_EN
   for (genvar c = 0; c < NCH; c++) begin : g_aout
      assign a_out[c] = code_to_volts(16'(code_out[c*W +: W]), W, VREF);
   end

   always @(posedge clk) begin
      if (eoc) begin
         for (int c = 0; c < NCH; c++) begin
            $display("dac_multich eoc: ch%0d code %0d -> %f V", c, code_out[c*W +: W],
                     code_to_volts(16'(code_out[c*W +: W]), W, VREF));
         end
      end
   end
`endif

endmodule

// File: tb/tb_dac_multich.sv
// Self-checking bench for dac_multich: transaction-level model plus directed and random stimulus.
module tb_dac_multich;

   localparam int  NCH        = 4;
   localparam int  W          = 12;
   localparam int  SETTLE_CYC = 4;
   localparam real VREF       = 3.3;
   localparam int  CHW        = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [CHW-1:0]    wr_ch;
   logic [W-1:0]      wr_data;
   logic              soc;
   logic              all_ch;
   logic [CHW-1:0]    soc_ch;
   logic              busy;
   logic              eoc;
   logic              ovr;
   logic [NCH*W-1:0]  code_out;
`ifdef DAC_REAL_OUT_EN
   real               a_out [NCH];
`endif

   dac_multich #(
      .NCH(NCH), .W(W), .SETTLE_CYC(SETTLE_CYC), .VREF(VREF)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_ch    (wr_ch),
      .wr_data  (wr_data),
      .soc      (soc),
      .all_ch   (all_ch),
      .soc_ch   (soc_ch),
      .busy     (busy),
      .eoc      (eoc),
      .ovr      (ovr),
      .code_out (code_out)
`ifdef DAC_REAL_OUT_EN
      ,
      .a_out    (a_out)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: one pending conversion record, due at an absolute edge number.
   int     stg    [NCH];
   int     snap_m [NCH];
   int     code_m [NCH];
   bit     pending;
   int     due;
   bit     all_m;
   int     ch_m;
   bit     eoc_m;
   bit     ovr_m;
   int     edge_no = 0;

   task automatic chk(input string nm, input longint got, input longint want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, got, want);
   endtask

   task automatic chk_v(input string nm, input real got, input real want);
      real d;
      n_chk++;
      d = got - want;
      if (d < 0.0) d = -d;
      if (d < 1.0e-5) n_pass++;
      else $display("FAIL %s: got %f V, expected %f V", nm, got, want);
   endtask

   function automatic int dut_code(input int c);
      return int'(code_out[c*W +: W]);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         stg[c] = 0; snap_m[c] = 0; code_m[c] = 0;
      end
      pending = 0; due = 0; all_m = 0; ch_m = 0; eoc_m = 0; ovr_m = 0;
   endtask

   task automatic model_edge();
      bit was_busy;
      edge_no++;
      if (!rst_n) begin
         model_reset();
         return;
      end
      was_busy = pending;
      eoc_m = 0;
      if (pending && edge_no == due) begin
         eoc_m = 1;
         for (int c = 0; c < NCH; c++)
            if (all_m || ch_m == c) code_m[c] = snap_m[c];
         pending = 0;
      end
      if (wr_en && int'(wr_ch) < NCH) stg[wr_ch] = int'(wr_data);
      if (soc) begin
         if (was_busy) ovr_m = 1;
         else begin
            snap_m  = stg;
            all_m   = all_ch;
            ch_m    = int'(soc_ch);
            due     = edge_no + SETTLE_CYC;
            pending = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("busy", busy, pending);
      chk("eoc", eoc, eoc_m);
      chk("ovr", ovr, ovr_m);
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("code_out[%0d]", c), dut_code(c), code_m[c]);
`ifdef DAC_REAL_OUT_EN
         chk_v($sformatf("a_out[%0d]", c), a_out[c], VREF * real'(code_m[c]) / real'(1 << W));
`endif
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_in();
      wr_en = 0; soc = 0; all_ch = 0;
   endtask

   task automatic wr(input int ch, input int d);
      wr_en = 1; wr_ch = CHW'(ch); wr_data = W'(d);
      step();
      wr_en = 0;
   endtask

   int eoc_seen;

   initial begin
      rst_n = 0; wr_en = 0; wr_ch = '0; wr_data = '0;
      soc = 0; all_ch = 0; soc_ch = '0;
      model_reset();
      repeat (2) step();
      chk("reset busy", busy, 0);
      chk("reset code_out", code_out, 0);
      rst_n = 1;
      step();

      // single-channel commit of ch0
      wr(0, 1000);
      soc = 1; soc_ch = 0; all_ch = 0;
      step();
      idle_in();
      chk("t1 busy at k", busy, 1);
      repeat (3) step();
      step();
      chk("t1 eoc at k+4", eoc, 1);
      chk("t1 ch0", dut_code(0), 1000);
      chk("t1 ch1", dut_code(1), 0);
`ifdef DAC_REAL_OUT_EN
      chk_v("t1 a_out0", a_out[0], 0.805664);
`endif
      step();
      chk("t1 eoc one cycle", eoc, 0);

      // simultaneous update
      wr(0, 1000); wr(1, 4000); wr(2, 500); wr(3, 4095);
      soc = 1; all_ch = 1;
      step();
      idle_in();
      repeat (3) step();
      chk("t2 ch3 held before eoc", dut_code(3), 0);
      step();
      chk("t2 ch1", dut_code(1), 4000);
      chk("t2 ch3", dut_code(3), 4095);
`ifdef DAC_REAL_OUT_EN
      chk_v("t2 a_out0", a_out[0], 0.805664);
      chk_v("t2 a_out1", a_out[1], 3.222656);
      chk_v("t2 a_out2", a_out[2], 0.402832);
      chk_v("t2 a_out3", a_out[3], 3.299194);
`endif
      step();

      // soc during conversion
      wr(2, 77);
      soc = 1; soc_ch = 2;
      step();
      soc = 0; step();
      soc = 1; soc_ch = 0; step();
      soc = 0; step();
      step();
      chk("t3 eoc", eoc, 1);
      chk("t3 ovr sticky", ovr, 1);
      chk("t3 ch2", dut_code(2), 77);
      chk("t3 ch0 untouched", dut_code(0), 1000);
      repeat (6) step();

      // write-through on the soc edge, later write ignored
      wr_en = 1; wr_ch = 1; wr_data = 2048;
      soc = 1; soc_ch = 1; all_ch = 0;
      step();
      soc = 0; wr_data = 100;
      step();
      wr_en = 0;
      repeat (3) step();
      chk("t4 ch1 write-through", dut_code(1), 2048);
      step();

      // reset mid-conversion
      soc = 1; soc_ch = 3;
      step();
      soc = 0;
      step();
      rst_n = 0;
      #1;
      model_reset();
      chk("t5 busy", busy, 0);
      chk("t5 eoc", eoc, 0);
      chk("t5 ovr", ovr, 0);
      chk("t5 code_out", code_out, 0);
      step(); step();
      rst_n = 1;
      eoc_seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (eoc) eoc_seen++;
      end
      chk("t5 no eoc after reset", eoc_seen, 0);

      // back-to-back conversions
      wr(3, 1234);
      soc = 1; soc_ch = 3; all_ch = 0;
      step();
      soc = 0;
      repeat (4) step();
      chk("t6 first eoc", eoc, 1);
      soc = 1; all_ch = 1;
      wr(0, 3333);
      soc = 0; all_ch = 0;
      repeat (3) step();
      step();
      chk("t6 second eoc", eoc, 1);
      chk("t6 ovr clear", ovr, 0);
      chk("t6 ch0", dut_code(0), 3333);
      chk("t6 ch3", dut_code(3), 1234);

      // random traffic
      for (int i = 0; i < 500; i++) begin
         wr_en   = ($urandom_range(0, 1) == 1);
         wr_ch   = CHW'($urandom_range(0, NCH - 1));
         wr_data = W'($urandom);
         soc     = ($urandom_range(0, 3) == 0);
         all_ch  = ($urandom_range(0, 1) == 1);
         soc_ch  = CHW'($urandom_range(0, NCH - 1));
         step();
      end
      idle_in();
      repeat (SETTLE_CYC + 2) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
